// File: rtl/rggen_apb_bridge_if.sv
// Request-side and APB-side signal bundle for rggen_apb_bridge.
// The master modport is the bridge's view; slave is the surrounding environment.
interface rggen_apb_bridge_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
);
    localparam int STRB_WIDTH = BUS_WIDTH / 8;

    logic                     i_bus_valid;
    logic [1:0]               i_bus_access;
    logic [ADDRESS_WIDTH-1:0] i_bus_address;
    logic [BUS_WIDTH-1:0]     i_bus_write_data;
    logic [STRB_WIDTH-1:0]    i_bus_strobe;
    logic                     o_bus_ready;
    logic [1:0]               o_bus_status;
    logic [BUS_WIDTH-1:0]     o_bus_read_data;

    logic                     o_psel;
    logic                     o_penable;
    logic [ADDRESS_WIDTH-1:0] o_paddr;
    logic [2:0]               o_pprot;
    logic                     o_pwrite;
    logic [STRB_WIDTH-1:0]    o_pstrb;
    logic [BUS_WIDTH-1:0]     o_pwdata;
    logic                     i_pready;
    logic [BUS_WIDTH-1:0]     i_prdata;
    logic                     i_pslverr;

    modport master (
        input  i_bus_valid, i_bus_access, i_bus_address, i_bus_write_data, i_bus_strobe,
        output o_bus_ready, o_bus_status, o_bus_read_data,
        output o_psel, o_penable, o_paddr, o_pprot, o_pwrite, o_pstrb, o_pwdata,
        input  i_pready, i_prdata, i_pslverr
    );

    modport slave (
        output i_bus_valid, i_bus_access, i_bus_address, i_bus_write_data, i_bus_strobe,
        input  o_bus_ready, o_bus_status, o_bus_read_data,
        input  o_psel, o_penable, o_paddr, o_pprot, o_pwrite, o_pstrb, o_pwdata,
        output i_pready, i_prdata, i_pslverr
    );
endinterface

// File: rtl/rggen_apb_bridge.sv
// rggen register-bus to APB4 master bridge (IDLE -> SETUP -> ACCESS).
// Optional ACCESS-phase timeout: define RGGEN_APB_BRIDGE_TIMEOUT_EN.
module rggen_apb_bridge #(
    parameter int         ADDRESS_WIDTH  = 8,
    parameter int         BUS_WIDTH      = 32,
    parameter logic [2:0] PPROT_VALUE    = 3'b000,
    parameter int         TIMEOUT_CYCLES = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    rggen_apb_bridge_if.master  bus_if
);
    localparam int STRB_WIDTH = BUS_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_e;

    state_e                   state_q, state_d;
    logic                     psel_q, psel_d;
    logic                     penable_q, penable_d;
    logic                     pwrite_q, pwrite_d;
    logic [ADDRESS_WIDTH-1:0] paddr_q, paddr_d;
    logic [STRB_WIDTH-1:0]    pstrb_q, pstrb_d;
    logic [BUS_WIDTH-1:0]     pwdata_q, pwdata_d;
    logic                     timeout;
    logic                     done;
    logic                     unused_access;

    assign unused_access = bus_if.i_bus_access[1];

`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES);

    logic [CNT_WIDTH-1:0] count_q, count_d;

    assign timeout = (state_q == ACCESS) && !bus_if.i_pready &&
                     (count_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

    always_comb begin
        count_d = count_q;
        if (state_q == SETUP) begin
            count_d = '0;
        end else if ((state_q == ACCESS) && !bus_if.i_pready && !timeout) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pstrb_d   = pstrb_q;
        pwdata_d  = pwdata_q;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus_if.i_bus_valid) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    paddr_d   = bus_if.i_bus_address;
                    pwrite_d  = bus_if.i_bus_access[0];
                    pwdata_d  = bus_if.i_bus_write_data;
                    pstrb_d   = bus_if.i_bus_access[0] ? bus_if.i_bus_strobe : '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (bus_if.i_pready || timeout) begin
                    done      = 1'b1;
                    state_d   = IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pstrb_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pstrb_q   <= pstrb_d;
            pwdata_q  <= pwdata_d;
        end
    end

    // A real slave response takes priority over a coincident timeout.
    assign bus_if.o_bus_ready     = done;
    assign bus_if.o_bus_status    = !done            ? 2'b00 :
                                    bus_if.i_pready  ? {bus_if.i_pslverr, 1'b0} : 2'b11;
    assign bus_if.o_bus_read_data = (done && bus_if.i_pready && !pwrite_q) ? bus_if.i_prdata : '0;

    assign bus_if.o_psel    = psel_q;
    assign bus_if.o_penable = penable_q;
    assign bus_if.o_paddr   = paddr_q;
    assign bus_if.o_pprot   = PPROT_VALUE;
    assign bus_if.o_pwrite  = pwrite_q;
    assign bus_if.o_pstrb   = pstrb_q;
    assign bus_if.o_pwdata  = pwdata_q;
endmodule

// File: tb/tb_rggen_apb_bridge.sv
// Bench for rggen_apb_bridge: transaction-level schedule model checked every cycle,
// plus literal expectations per directed transfer.
module tb_rggen_apb_bridge;
    localparam int         AW   = 8;
    localparam int         BW   = 32;
    localparam int         SW   = BW / 8;
    localparam int         TO   = 4;
    localparam logic [2:0] PPROT = 3'b010;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rggen_apb_bridge_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) bif ();

    rggen_apb_bridge #(
        .ADDRESS_WIDTH (AW),
        .BUS_WIDTH     (BW),
        .PPROT_VALUE   (PPROT),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus_if (bif)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit            active;
        int            n;
        bit            wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] wdata;
        logic [SW-1:0] strb;
        int            waits;
        bit            err;
        logic [BW-1:0] rdata;
    } txn_t;

    txn_t          t;
    int            ready_cnt, ready_rel, ready_cyc, setup_cyc;
    logic [1:0]    ready_status;
    logic [BW-1:0] ready_data;
    logic [SW-1:0] setup_strb;
    logic          setup_pwrite;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Number of wait cycles the bridge actually tolerates before completing.
    function automatic int eff_waits(input int w);
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
        return (w > TO - 1) ? TO - 1 : w;
`else
        return w;
`endif
    endfunction

    function automatic bit timed_out(input int w);
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
        return w > TO - 1;
`else
        return (w < 0);
`endif
    endfunction

    always @(negedge clk) begin : cmp
        int            rel;
        int            e_end;
        bit            in_txn;
        bit            e_ready;
        logic [1:0]    e_status;
        logic [BW-1:0] e_rdata;
        if (cyc >= 1) begin
            rel    = 0;
            e_end  = 0;
            in_txn = 1'b0;
            if (rst_n && t.active) begin
                rel    = cyc - t.n;
                e_end  = 2 + eff_waits(t.waits);
                in_txn = (rel >= 1) && (rel <= e_end);
            end
            e_ready  = in_txn && (rel == e_end);
            e_status = !e_ready ? 2'b00 : (timed_out(t.waits) ? 2'b11 : {t.err, 1'b0});
            e_rdata  = (e_ready && !timed_out(t.waits) && !t.wr) ? t.rdata : '0;
            chk("pprot", bif.o_pprot, PPROT);
            chk("psel", bif.o_psel, in_txn);
            chk("penable", bif.o_penable, in_txn && (rel >= 2));
            chk("bus_ready", bif.o_bus_ready, e_ready);
            chk("bus_status", bif.o_bus_status, e_status);
            chk("bus_read_data", bif.o_bus_read_data, e_rdata);
            if (in_txn) begin
                chk("paddr", bif.o_paddr, t.addr);
                chk("pwrite", bif.o_pwrite, t.wr);
                chk("pwdata", bif.o_pwdata, t.wdata);
                chk("pstrb", bif.o_pstrb, t.wr ? t.strb : '0);
            end
            if (bif.o_psel && !bif.o_penable) begin
                setup_cyc    = cyc;
                setup_strb   = bif.o_pstrb;
                setup_pwrite = bif.o_pwrite;
            end
            if (bif.o_bus_ready) begin
                ready_cnt++;
                ready_rel    = rel;
                ready_cyc    = cyc;
                ready_status = bif.o_bus_status;
                ready_data   = bif.o_bus_read_data;
            end
        end
    end

    task automatic noise();
        bif.i_pready  = 1'($urandom_range(1, 0));
        bif.i_prdata  = $urandom;
        bif.i_pslverr = 1'($urandom_range(1, 0));
    endtask

    // Entered and left at posedge+1; the slave answers after `waits` wait states.
    task automatic run_txn(input bit wr, input logic [AW-1:0] a, input logic [BW-1:0] d,
                           input logic [SW-1:0] s, input int waits, input bit err,
                           input logic [BW-1:0] rd, input int limit);
        int rel;
        int e_end;
        t.active = 1'b1; t.n = cyc; t.wr = wr; t.addr = a; t.wdata = d; t.strb = s;
        t.waits = waits; t.err = err; t.rdata = rd;
        ready_cnt = 0;
        e_end = 2 + eff_waits(waits);
        bif.i_bus_valid      = 1'b1;
        bif.i_bus_access     = {1'($urandom_range(1, 0)), wr};
        bif.i_bus_address    = a;
        bif.i_bus_write_data = d;
        bif.i_bus_strobe     = s;
        noise();
        for (int k = 0; k < 5000; k++) begin
            @(posedge clk); #1;
            rel = cyc - t.n;
            if (rel > e_end || rel > limit) begin
                bif.i_bus_valid = 1'b0;
                bif.i_pready    = 1'b0;
                return;
            end
            bif.i_bus_access     = 2'($urandom_range(3, 0));
            bif.i_bus_address    = AW'($urandom);
            bif.i_bus_write_data = $urandom;
            bif.i_bus_strobe     = SW'($urandom);
            if (rel >= 2) begin
                bif.i_pready  = (rel == 2 + waits);
                bif.i_prdata  = (rel == 2 + waits) ? rd : $urandom;
                bif.i_pslverr = (rel == 2 + waits) ? err : 1'($urandom_range(1, 0));
            end else begin
                noise();
            end
        end
        chk("txn_budget", 1'b1, 1'b0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_psel"}, bif.o_psel, 1'b0);
        chk({tag, "_penable"}, bif.o_penable, 1'b0);
        chk({tag, "_pwrite"}, bif.o_pwrite, 1'b0);
        chk({tag, "_paddr"}, bif.o_paddr, 0);
        chk({tag, "_pstrb"}, bif.o_pstrb, 0);
        chk({tag, "_pwdata"}, bif.o_pwdata, 0);
        chk({tag, "_ready"}, bif.o_bus_ready, 1'b0);
        chk({tag, "_status"}, bif.o_bus_status, 2'b00);
        chk({tag, "_rdata"}, bif.o_bus_read_data, 0);
    endtask

    // Called at posedge+1 with the bridge mid-transfer.
    task automatic mid_reset(input string tag);
        #1;
        rst_n    = 1'b0;
        t.active = 1'b0;
        #1;
        chk({tag, "_async_psel"}, bif.o_psel, 1'b0);
        chk({tag, "_async_penable"}, bif.o_penable, 1'b0);
        chk({tag, "_async_ready"}, bif.o_bus_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset_checks(tag);
        chk({tag, "_no_completion"}, ready_cnt, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        int r1;
        t = '{default: 0};
        ready_cnt = 0; ready_rel = 0; ready_cyc = 0; setup_cyc = 0;
        bif.i_bus_valid = 1'b0; bif.i_bus_access = 2'b00; bif.i_bus_address = '0;
        bif.i_bus_write_data = '0; bif.i_bus_strobe = '0;
        bif.i_pready = 1'b0; bif.i_prdata = '0; bif.i_pslverr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_checks("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0, 5000);
        $display("txn write 10 deadbeef: ready_rel=%0d status=%0b", ready_rel, ready_status);
        chk("t1_setup_strb", setup_strb, 4'hF);
        chk("t1_setup_pwrite", setup_pwrite, 1'b1);
        chk("t1_setup_rel", setup_cyc - t.n, 1);
        chk("t1_ready_rel", ready_rel, 2);
        chk("t1_status", ready_status, 2'b00);
        chk("t1_ready_cnt", ready_cnt, 1);
        @(posedge clk); #1;

        run_txn(1'b0, 8'h04, 32'hA5A5A5A5, 4'h3, 3, 1'b0, 32'h12345678, 5000);
        $display("txn read 04 waits=3: data=%h status=%0b", ready_data, ready_status);
        chk("t2_setup_strb", setup_strb, 4'h0);
        chk("t2_ready_rel", ready_rel, 5);
        chk("t2_read_data", ready_data, 32'h12345678);
        chk("t2_status", ready_status, 2'b00);
        @(posedge clk); #1;

        run_txn(1'b1, 8'h20, 32'h0BADF00D, 4'h5, 1, 1'b1, 32'h0, 5000);
        $display("txn write 20 slverr: status=%0b count=%0d", ready_status, ready_cnt);
        chk("t3_status", ready_status, 2'b10);
        chk("t3_ready_cnt", ready_cnt, 1);
        chk("t3_read_data", ready_data, 0);

        run_txn(1'b0, 8'h08, 32'h0, 4'h0, 0, 1'b0, 32'hCAFEF00D, 5000);
        r1 = ready_cyc;
        chk("t4a_read_data", ready_data, 32'hCAFEF00D);
        run_txn(1'b1, 8'h0C, 32'h11223344, 4'hC, 2, 1'b0, 32'h0, 5000);
        $display("txn back-to-back: gap=%0d", setup_cyc - r1);
        chk("t4_setup_gap", setup_cyc - r1, 2);
        chk("t4b_ready_rel", ready_rel, 4);

        run_txn(1'b1, 8'h30, 32'h55AA55AA, 4'hF, 5, 1'b0, 32'h0, 3);
        mid_reset("t5");
        $display("txn reset mid-access: completions=%0d", ready_cnt);
        run_txn(1'b0, 8'h34, 32'h0, 4'h0, 1, 1'b0, 32'h87654321, 5000);
        $display("txn after reset read 34: data=%h", ready_data);
        chk("t5_fresh_ready_rel", ready_rel, 3);
        chk("t5_fresh_data", ready_data, 32'h87654321);
        @(posedge clk); #1;

`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
        run_txn(1'b0, 8'h40, 32'h0, 4'h0, 1000, 1'b0, 32'hFFFFFFFF, 5000);
        $display("txn timeout: ready_rel=%0d status=%0b", ready_rel, ready_status);
        chk("t6_ready_rel", ready_rel, 5);
        chk("t6_status", ready_status, 2'b11);
        chk("t6_read_data", ready_data, 0);
        chk("t6_ready_cnt", ready_cnt, 1);
        @(posedge clk); #1;
        run_txn(1'b1, 8'h44, 32'h1, 4'h1, TO - 1, 1'b1, 32'h0, 5000);
        $display("txn ready at limit: status=%0b", ready_status);
        chk("t7_ready_rel", ready_rel, 5);
        chk("t7_status", ready_status, 2'b10);
`else
        run_txn(1'b0, 8'h40, 32'h0, 4'h0, 1000, 1'b0, 32'hFFFFFFFF, 102);
        $display("txn no-timeout hang: completions=%0d", ready_cnt);
        chk("t6_still_psel", bif.o_psel, 1'b1);
        chk("t6_still_penable", bif.o_penable, 1'b1);
        chk("t6_no_ready", ready_cnt, 0);
        mid_reset("t6");
        run_txn(1'b1, 8'h48, 32'h9, 4'h8, 0, 1'b0, 32'h0, 5000);
        chk("t6_fresh_ready_rel", ready_rel, 2);
`endif
        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rggen_apb_bridge.md
Name: rggen_apb_bridge

Overview:
APB master bridge that converts the rggen internal register-bus request (valid/access/address/write_data/strobe) into APB4 transfers. It sits upstream of an APB slave register block and drives the slave's psel/penable/paddr/... inputs. It returns pready/prdata/pslverr to the requester as bus ready/read data/status. It is used to chain register blocks behind a host-side rggen bus or interconnect.

Parameters:
ADDRESS_WIDTH, 8, width of bus and APB address
BUS_WIDTH, 32, data width (multiple of 8)
PPROT_VALUE, 3'b000, constant driven on o_pprot
TIMEOUT_CYCLES, 16, ACCESS-phase cycle limit; used only with the optional feature (>=2)

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_bus_valid  input  1  request valid; held until o_bus_ready
i_bus_access  input  2  bit0: 1=write, 0=read; bit1 ignored
i_bus_address  input  ADDRESS_WIDTH  byte address
i_bus_write_data  input  BUS_WIDTH  write data
i_bus_strobe  input  BUS_WIDTH/8  byte strobes
o_bus_ready  output  1  completion pulse
o_bus_status  output  2  2'b00 OKAY, 2'b10 SLVERR, 2'b11 timeout
o_bus_read_data  output  BUS_WIDTH  read data, valid with o_bus_ready
o_psel  output  1  APB select
o_penable  output  1  APB enable
o_paddr  output  ADDRESS_WIDTH  APB address
o_pprot  output  3  APB protection
o_pwrite  output  1  APB direction
o_pstrb  output  BUS_WIDTH/8  APB strobes
o_pwdata  output  BUS_WIDTH  APB write data
i_pready  input  1  slave ready
i_prdata  input  BUS_WIDTH  slave read data
i_pslverr  input  1  slave error

Behaviour:
- Clock i_clk; reset i_rst_n is asynchronous, active-low. Reset forces state IDLE. o_psel, o_penable, o_pwrite, o_paddr, o_pstrb, o_pwdata, o_bus_ready, o_bus_status and o_bus_read_data are all 0. o_pprot is constant PPROT_VALUE.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: if i_bus_valid, then at the next edge go to SETUP and register the request: o_psel=1, o_penable=0, o_paddr=address, o_pwrite=access[0], o_pwdata=write_data. o_pstrb=strobe for writes and 0 for reads.
- SETUP: unconditionally go to ACCESS next edge with o_penable=1.
- ACCESS: APB outputs are held stable until i_pready=1.
  - When i_pready=1, o_bus_ready=1 combinationally in that cycle.
  - o_bus_status={i_pslverr,1'b0}.
  - o_bus_read_data=i_prdata for reads, 0 for writes.
  - Next edge: IDLE with o_psel=0 and o_penable=0.
- o_bus_ready is 0 in every other state and cycle. Read data and status are only meaningful while o_bus_ready=1; otherwise they are 0.
- Latency: request seen in IDLE at cycle N means SETUP at N+1, ACCESS at N+2, earliest o_bus_ready at N+2. Minimum 3 cycles per transfer, including 1 IDLE cycle between back-to-back transfers.
- i_bus_* changes while not in IDLE are ignored, because the registered copy drives APB.
- A request asserted in the cycle right after o_bus_ready is a new transfer.
- Reset mid-transfer: o_psel/o_penable drop immediately and no completion is issued.

Optional Feature:
Macro RGGEN_APB_BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with i_pready=0.
  - When it reaches TIMEOUT_CYCLES-1 with i_pready still 0, the bridge asserts o_bus_ready=1 with o_bus_status=2'b11 and o_bus_read_data=0, then returns to IDLE and drops o_psel/o_penable.
  - If i_pready=1 in the same cycle as the limit, the normal response wins.
- Undefined: the counter is not built and ACCESS waits indefinitely for i_pready.

Test Plan:
- Write addr 8'h10, data 32'hDEADBEEF, strobe 4'hF; i_pready=1 on first ACCESS cycle. Required: SETUP at N+1 with o_pstrb=4'hF and o_pwrite=1, o_bus_ready=1 at N+2 with status 2'b00, o_psel=0 at N+3.
- Read addr 8'h04 with 3 wait states, i_prdata=32'h12345678 on the ready cycle. Required: APB signals stable 3 cycles, o_pstrb=0, o_bus_read_data=32'h12345678, status 2'b00.
- Write with i_pslverr=1 on the ready cycle. Required: o_bus_status=2'b10 for one cycle.
- Back-to-back: read, then write asserted the cycle after o_bus_ready. Required: exactly one IDLE cycle between the two SETUP phases.
- Assert i_rst_n=0 during ACCESS. Required: o_psel/o_penable drop to 0 asynchronously, no o_bus_ready; a fresh transfer after reset completes normally.
- With macro defined, TIMEOUT_CYCLES=4, i_pready held 0. Required: o_bus_ready with status 2'b11 on the 4th ACCESS cycle, then o_psel=0. Without the macro, the bridge stays in ACCESS after 100 cycles.
